// File: rtl/main_mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : main_mem_resp_pkg
// Purpose  : Shared types and constants for the main-memory responder.
//            - mem_resp_state_t : responder FSM state encoding
//            - LAT_MIN/LAT_MAX  : legal range of the LATENCY parameter
//            - CNT_W            : width of the latency down-counter
// Revision : 1.0 - initial release
// ============================================================================
package main_mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_RD = 2'd1,
        BUSY_WR = 2'd2,
        DONE    = 2'd3
    } mem_resp_state_t;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;

endpackage : main_mem_resp_pkg
`default_nettype wire

// File: rtl/mem_array_sp.sv
`default_nettype none
// ============================================================================
// Module   : mem_array_sp
// Purpose  : Single-port word array, synchronous write, asynchronous read.
//            Contents are never reset.
// Ports    : clock - rising-edge clock
//            we    - write enable, commits din to addr on the clock edge
//            addr  - word address (shared by read and write)
//            din   - write data
//            dout  - combinational read data at addr
// Revision : 1.0 - initial release
// ============================================================================
module mem_array_sp #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout
);

    logic [DWIDTH-1:0] mem_q [2**AWIDTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= din;
        end
    end

    assign dout = mem_q[addr];

endmodule : mem_array_sp
`default_nettype wire

// File: rtl/main_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : main_mem_responder
// Purpose  : Main-memory side of the cache/memory handshake. Accepts one
//            single-word read or write at a time and holds ready_mem low for
//            LATENCY cycles per request. Read data is registered on
//            data_mem_in and held until the next read completes.
// Ports    : clock, reset_n       - clock, asynchronous active-low reset
//            addr_mem             - request word address
//            rd_mem / wr_mem      - one-cycle request strobes
//            data_mem_out         - write data from the cache
//            data_mem_in          - read data to the cache (registered)
//            ready_mem            - high when able to accept a request
//            proto_err            - sticky protocol-violation flag
//            rd_count / wr_count  - accepted-request counters, saturating
//                                   (only when MAIN_MEM_RESP_STATS_EN defined)
// Config   : `define MAIN_MEM_RESP_STATS_EN to add the request counters.
// Revision : 1.0 - initial release
// ============================================================================
module main_mem_responder
    import main_mem_resp_pkg::*;
#(
    parameter int AWIDTH  = 9,
    parameter int DWIDTH  = 32,
    parameter int LATENCY = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [AWIDTH-1:0] addr_mem,
    input  logic              rd_mem,
    input  logic              wr_mem,
    input  logic [DWIDTH-1:0] data_mem_out,
    output logic [DWIDTH-1:0] data_mem_in,
    output logic              ready_mem,
`ifdef MAIN_MEM_RESP_STATS_EN
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
`endif
    output logic              proto_err
);

    generate
        if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_lat_check
            $error("main_mem_responder: LATENCY out of range 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY - 1);

    mem_resp_state_t   state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [DWIDTH-1:0] rdata_q;
    logic              ready_q;
    logic              perr_q;

    logic              can_accept;
    logic              accept_wr;
    logic              accept_rd;
    logic              mem_we;
    logic [DWIDTH-1:0] mem_dout;

    // DONE accepts requests exactly like IDLE. A simultaneous rd+wr is
    // treated as a write, so the read path only fires when wr_mem is low.
    assign can_accept = (state_q == IDLE) || (state_q == DONE);
    assign accept_wr  = can_accept && wr_mem;
    assign accept_rd  = can_accept && rd_mem && !wr_mem;

    // The write commits on the completion edge. Being decoded from the
    // registered state, an asynchronous reset in BUSY_WR drops it at once
    // and the pending write is discarded.
    assign mem_we = (state_q == BUSY_WR) && (cnt_q == '0);

    mem_array_sp #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_array (
        .clock (clock),
        .we    (mem_we),
        .addr  (addr_q),
        .din   (wdata_q),
        .dout  (mem_dout)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b1;
            perr_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept_wr) begin
                        addr_q  <= addr_mem;
                        wdata_q <= data_mem_out;
                        cnt_q   <= LAT_INIT;
                        ready_q <= 1'b0;
                        state_q <= BUSY_WR;
                        if (rd_mem) begin
                            perr_q <= 1'b1;
                        end
                    end else if (accept_rd) begin
                        addr_q  <= addr_mem;
                        cnt_q   <= LAT_INIT;
                        ready_q <= 1'b0;
                        state_q <= BUSY_RD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY_RD, BUSY_WR: begin
                    // Strobes while busy are dropped but flagged.
                    if (rd_mem || wr_mem) begin
                        perr_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        ready_q <= 1'b1;
                        if (state_q == BUSY_RD) begin
                            rdata_q <= mem_dout;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign data_mem_in = rdata_q;
    assign ready_mem   = ready_q;
    assign proto_err   = perr_q;

`ifdef MAIN_MEM_RESP_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (accept_rd && (rd_cnt_q != 16'hFFFF)) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (accept_wr && (wr_cnt_q != 16'hFFFF)) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif

endmodule : main_mem_responder
`default_nettype wire
